// File: rtl/reg_file_32x32.sv
// rtl/reg_file_32x32.sv - 32-entry general-purpose register file, two operand read ports, one debug read port
// One synchronous write port driven by write-back; all reads are combinational.
module reg_file_32x32 #(
  parameter int unsigned DATA_W   = 32,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs_addr,
  input  logic [4:0]        rt_addr,
  input  logic [4:0]        dbg_addr,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_en,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [32];
  logic [DATA_W-1:0] regs_d [32];
  logic [31:0]       wr_strobe;

  // One-hot decode of the destination select; r0 is never strobed when hardwired.
  always_comb begin
    wr_strobe = '0;
    if (wr_en) begin
      wr_strobe[wr_addr] = 1'b1;
    end
    if (ZERO_REG) begin
      wr_strobe[0] = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = wr_strobe[i] ? wr_data : regs_q[i];
    end
  end

  // Reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Operand ports may forward the in-flight write; the r0 rule overrides forwarding.
  always_comb begin
    rs_data = regs_q[rs_addr];
    if (BYPASS && wr_en && (wr_addr == rs_addr)) begin
      rs_data = wr_data;
    end
    if (ZERO_REG && (rs_addr == 5'd0)) begin
      rs_data = '0;
    end
  end

  always_comb begin
    rt_data = regs_q[rt_addr];
    if (BYPASS && wr_en && (wr_addr == rt_addr)) begin
      rt_data = wr_data;
    end
    if (ZERO_REG && (rt_addr == 5'd0)) begin
      rt_data = '0;
    end
  end

  // Debug view always shows committed storage.
  always_comb begin
    dbg_data = regs_q[dbg_addr];
    if (ZERO_REG && (dbg_addr == 5'd0)) begin
      dbg_data = '0;
    end
  end

endmodule
